// File: rtl/cavlc_pkg.sv
// Shared types for the CAVLC block scheduler: FSM states, captured result record, block geometry.
package cavlc_pkg;

    localparam int CAVLC_BLK_COEFFS = 16;
    localparam int CAVLC_COEFF_W    = 8;
    localparam int CAVLC_BLK_W      = CAVLC_BLK_COEFFS * CAVLC_COEFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } cavlc_state_t;

    typedef struct packed {
        logic [1:0] t1_cnt;
        logic [2:0] t1_flag;
        logic [3:0] tz_cnt;
        logic [3:0] tc_cnt;
        logic [3:0] blk_idx;
    } cavlc_res_t;

    function automatic logic [3:0] cavlc_idx_inc(input logic [3:0] idx, input int blks);
        return (idx == 4'(blks - 1)) ? 4'd0 : idx + 4'd1;
    endfunction

endpackage

// File: rtl/cavlc_lat_timer.sv
// Loadable down-counter covering the core scan latency; done_o flags a zero count.
module cavlc_lat_timer #(
    parameter int SCAN_LAT = 17,
    parameter int CNT_W    = $clog2(SCAN_LAT)
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(SCAN_LAT - 1);
        end else if (en_i) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cavlc_blk_sched.sv
// Feeds one 4x4 block at a time to the CAVLC statistics core and returns its indexed result.
// Optional CAVLC_SKIP_ZERO_BLK_EN: all-zero blocks bypass the core and return zero stats next cycle.
module cavlc_blk_sched
    import cavlc_pkg::*;
#(
    parameter int SCAN_LAT = 17,
    parameter int MB_BLKS  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_sync_i,
    input  logic                   blk_valid_i,
    output logic                   blk_ready_o,
    input  logic [CAVLC_BLK_W-1:0] blk_coeff_i,
    output logic                   core_valid_o,
    output logic [CAVLC_BLK_W-1:0] core_scale_o,
    input  logic [1:0]             core_t1_cnt_i,
    input  logic [2:0]             core_t1_flag_i,
    input  logic [3:0]             core_tz_cnt_i,
    input  logic [3:0]             core_tc_cnt_i,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [1:0]             res_t1_cnt_o,
    output logic [2:0]             res_t1_flag_o,
    output logic [3:0]             res_tz_cnt_o,
    output logic [3:0]             res_tc_cnt_o,
    output logic [3:0]             res_blk_idx_o,
    output logic                   res_mb_last_o
);

    cavlc_state_t           state_q;
    logic                   blk_ready_q;
    logic                   core_valid_q;
    logic                   res_valid_q;
    logic [CAVLC_BLK_W-1:0] core_scale_q;
    cavlc_res_t             res_q;
    logic [3:0]             blk_idx_q;
    logic [3:0]             blk_idx_d;
    logic                   accept;
    logic                   tmr_load;
    logic                   tmr_en;
    logic                   tmr_done;

    assign accept    = blk_valid_i & blk_ready_q;
    assign blk_idx_d = cavlc_idx_inc(blk_idx_q, MB_BLKS);
    assign tmr_load  = (state_q == ISSUE);
    assign tmr_en    = (state_q == WAIT) && !tmr_done;

    cavlc_lat_timer #(
        .SCAN_LAT (SCAN_LAT)
    ) u_lat_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .en_i   (tmr_en),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            blk_ready_q  <= 1'b1;
            core_valid_q <= 1'b0;
            res_valid_q  <= 1'b0;
            core_scale_q <= '0;
            res_q        <= '0;
            blk_idx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_sync_i) begin
                        blk_idx_q <= '0;
                    end
                    if (accept) begin
                        core_scale_q <= blk_coeff_i;
                        blk_ready_q  <= 1'b0;
`ifdef CAVLC_SKIP_ZERO_BLK_EN
                        if (blk_coeff_i == '0) begin
                            // Zero block: statistics are trivially zero, the core is never started.
                            res_q.t1_cnt  <= '0;
                            res_q.t1_flag <= '0;
                            res_q.tz_cnt  <= '0;
                            res_q.tc_cnt  <= '0;
                            res_q.blk_idx <= frame_sync_i ? 4'd0 : blk_idx_q;
                            res_valid_q   <= 1'b1;
                            state_q       <= HOLD;
                        end else begin
                            core_valid_q <= 1'b1;
                            state_q      <= ISSUE;
                        end
`else
                        core_valid_q <= 1'b1;
                        state_q      <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    core_valid_q <= 1'b0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (tmr_done) begin
                        res_q.t1_cnt  <= core_t1_cnt_i;
                        res_q.t1_flag <= core_t1_flag_i;
                        res_q.tz_cnt  <= core_tz_cnt_i;
                        res_q.tc_cnt  <= core_tc_cnt_i;
                        res_q.blk_idx <= blk_idx_q;
                        res_valid_q   <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        blk_ready_q <= 1'b1;
                        blk_idx_q   <= blk_idx_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign blk_ready_o   = blk_ready_q;
    assign core_valid_o  = core_valid_q;
    assign core_scale_o  = core_scale_q;
    assign res_valid_o   = res_valid_q;
    assign res_t1_cnt_o  = res_q.t1_cnt;
    assign res_t1_flag_o = res_q.t1_flag;
    assign res_tz_cnt_o  = res_q.tz_cnt;
    assign res_tc_cnt_o  = res_q.tc_cnt;
    assign res_blk_idx_o = res_q.blk_idx;
    assign res_mb_last_o = (res_q.blk_idx == 4'(MB_BLKS - 1));

endmodule

// File: tb/tb_cavlc_blk_sched.sv
// Scoreboard bench for cavlc_blk_sched with a latency-accurate model of the statistics core.
module tb_cavlc_blk_sched;

    localparam int SCAN_LAT = 17;
    localparam int TMO      = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         frame_sync_i = 1'b0;
    logic         blk_valid_i = 1'b0;
    logic         blk_ready_o;
    logic [127:0] blk_coeff_i = '0;
    logic         core_valid_o;
    logic [127:0] core_scale_o;
    logic [1:0]   core_t1_cnt_i = '0;
    logic [2:0]   core_t1_flag_i = '0;
    logic [3:0]   core_tz_cnt_i = '0;
    logic [3:0]   core_tc_cnt_i = '0;
    logic         res_valid_o;
    logic         res_ready_i = 1'b1;
    logic [1:0]   res_t1_cnt_o;
    logic [2:0]   res_t1_flag_o;
    logic [3:0]   res_tz_cnt_o;
    logic [3:0]   res_tc_cnt_o;
    logic [3:0]   res_blk_idx_o;
    logic         res_mb_last_o;

    cavlc_blk_sched #(.SCAN_LAT(SCAN_LAT), .MB_BLKS(16)) dut (
        .clk(clk), .rst(rst), .frame_sync_i(frame_sync_i),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_coeff_i(blk_coeff_i),
        .core_valid_o(core_valid_o), .core_scale_o(core_scale_o),
        .core_t1_cnt_i(core_t1_cnt_i), .core_t1_flag_i(core_t1_flag_i),
        .core_tz_cnt_i(core_tz_cnt_i), .core_tc_cnt_i(core_tc_cnt_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_t1_cnt_o(res_t1_cnt_o), .res_t1_flag_o(res_t1_flag_o),
        .res_tz_cnt_o(res_tz_cnt_o), .res_tc_cnt_o(res_tc_cnt_o),
        .res_blk_idx_o(res_blk_idx_o), .res_mb_last_o(res_mb_last_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] flds;   // {t1, flag, tz, tc, idx, mb_last}
        int          acc;
        int          lat;
    } sb_ent_t;

    typedef struct {
        logic [127:0] coeff;
        logic [12:0]  resp;  // {t1, flag, tz, tc}
        int           acc;
    } core_ent_t;

    sb_ent_t   sb_q[$];
    core_ent_t core_q[$];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core model: garbage until SCAN_LAT cycles after the pulse, then the true result until the next pulse.
    core_ent_t cur_core;
    bit        core_busy = 1'b0;
    int        core_age  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            core_busy = 1'b0;
        end else if (core_valid_o) begin
            chk("core_no_overlap", 128'(core_busy), 128'(0));
            if (core_q.size() == 0) begin
                chk("core_unexpected_pulse", 128'(1), 128'(0));
            end else begin
                cur_core = core_q.pop_front();
                chk("core_pulse_latency", 128'(cyc - cur_core.acc), 128'(1));
                chk("core_scale", core_scale_o, cur_core.coeff);
                core_busy = 1'b1;
                core_age  = 0;
                {core_t1_cnt_i, core_t1_flag_i, core_tz_cnt_i, core_tc_cnt_i} = ~cur_core.resp;
            end
        end else if (core_busy) begin
            core_age++;
            if (core_scale_o !== cur_core.coeff)
                chk("core_scale_stable", core_scale_o, cur_core.coeff);
            if (core_age == SCAN_LAT) begin
                {core_t1_cnt_i, core_t1_flag_i, core_tz_cnt_i, core_tc_cnt_i} = cur_core.resp;
                core_busy = 1'b0;
            end
        end
    end

    // Result monitor.
    bit      seen_first = 1'b0;
    sb_ent_t cur_sb;
    always @(negedge clk) begin
        if (!rst) begin
            seen_first = 1'b0;
        end else if (res_valid_o) begin
            if (sb_q.size() == 0) begin
                chk("res_unexpected", 128'(1), 128'(0));
            end else begin
                cur_sb = sb_q[0];
                chk("res_fields", {res_t1_cnt_o, res_t1_flag_o, res_tz_cnt_o, res_tc_cnt_o,
                                   res_blk_idx_o, res_mb_last_o}, cur_sb.flds);
                chk("blk_ready_in_hold", 128'(blk_ready_o), 128'(0));
                if (!seen_first) begin
                    chk("res_latency", 128'(cyc - cur_sb.acc), 128'(cur_sb.lat));
                    seen_first = 1'b1;
                end
                if (res_ready_i) begin
                    void'(sb_q.pop_front());
                    seen_first = 1'b0;
                end
            end
        end
    end

    task automatic send_blk(input logic [127:0] c, input logic [1:0] t1, input logic [2:0] fl,
                            input logic [3:0] tz, input logic [3:0] tc, input logic [3:0] idx,
                            input bit fs, input bit expect_res);
        int        n = 0;
        bit        skip;
        sb_ent_t   s;
        core_ent_t e;
`ifdef CAVLC_SKIP_ZERO_BLK_EN
        skip = (c == '0);
`else
        skip = 1'b0;
`endif
        blk_valid_i  = 1'b1;
        blk_coeff_i  = c;
        frame_sync_i = fs;
        @(negedge clk);
        while (!blk_ready_o && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) begin
            chk("accept_timeout", 128'(1), 128'(0));
        end else begin
            if (expect_res) begin
                s.flds = {t1, fl, tz, tc, idx, (idx == 4'd15)};
                s.acc  = cyc;
                s.lat  = skip ? 1 : SCAN_LAT + 2;
                sb_q.push_back(s);
            end
            if (!skip) begin
                e.coeff = c;
                e.resp  = {t1, fl, tz, tc};
                e.acc   = cyc;
                core_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        blk_valid_i  = 1'b0;
        frame_sync_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < TMO) begin
            @(posedge clk);
            n++;
        end
        if (n >= TMO) chk("drain_timeout", 128'(sb_q.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] c;
        int           n;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_blk_ready", 128'(blk_ready_o), 128'(1));
        chk("rst_res_valid", 128'(res_valid_o), 128'(0));
        chk("rst_core_valid", 128'(core_valid_o), 128'(0));
        chk("rst_core_scale", core_scale_o, 128'(0));
        chk("rst_blk_idx", 128'(res_blk_idx_o), 128'(0));
        chk("rst_mb_last", 128'(res_mb_last_o), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single block {0,3,-1,0,0,-1,1,0,...}: tc=4 t1=3 tz=3.
        c = '0;
        c[15:8]  = 8'd3;
        c[23:16] = 8'hFF;
        c[47:40] = 8'hFF;
        c[55:48] = 8'd1;
        send_blk(c, 2'd3, 3'b110, 4'd3, 4'd4, 4'd0, 1'b0, 1'b1);
        drain();

        // Back-pressure for 10 cycles while the result is held.
        res_ready_i = 1'b0;
        c = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
        send_blk(c, 2'd1, 3'b001, 4'd0, 4'd15, 4'd1, 1'b0, 1'b1);
        n = 0;
        while (!res_valid_o && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_res_valid_seen", 128'(res_valid_o), 128'(1));
        repeat (10) @(posedge clk);
        #1;
        res_ready_i = 1'b1;
        drain();

        // Reset while the timer reads 5: block aborted, index back to 0.
        send_blk(128'h55, 2'd2, 3'b010, 4'd7, 4'd2, 4'd2, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_blk_ready", 128'(blk_ready_o), 128'(1));
        chk("mrst_res_valid", 128'(res_valid_o), 128'(0));
        chk("mrst_core_valid", 128'(core_valid_o), 128'(0));
        chk("mrst_blk_idx", 128'(res_blk_idx_o), 128'(0));
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;

        // Stream 17 blocks: indices 0..15 then wrap to 0.
        for (int i = 0; i < 17; i++) begin
            send_blk({16{8'(i + 1)}}, 2'(i % 4), 3'(i % 8), 4'(15 - (i % 16)), 4'(i % 16),
                     4'(i % 16), 1'b0, 1'b1);
        end
        drain();

        // Three blocks (idx 1..3), then frame sync in IDLE.
        for (int i = 0; i < 3; i++) begin
            send_blk({8'h80, 120'(i + 7)}, 2'd1, 3'b100, 4'd2, 4'd3, 4'(i + 1), 1'b0, 1'b1);
        end
        drain();
        frame_sync_i = 1'b1;
        @(posedge clk);
        #1;
        frame_sync_i = 1'b0;
        send_blk(128'h7F, 2'd0, 3'b000, 4'd0, 4'd1, 4'd0, 1'b0, 1'b1);

        // Frame sync pulsed during WAIT must not disturb the index.
        send_blk(128'h0300, 2'd1, 3'b000, 4'd1, 4'd1, 4'd1, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        frame_sync_i = 1'b1;
        @(posedge clk);
        #1;
        frame_sync_i = 1'b0;
        send_blk(128'hFE00_0000, 2'd1, 3'b001, 4'd3, 4'd1, 4'd2, 1'b0, 1'b1);

        // Frame sync coincident with accept gives the accepted block index 0.
        send_blk(128'h1_0000, 2'd0, 3'b000, 4'd2, 4'd1, 4'd0, 1'b1, 1'b1);

        // All-zero block: bypass path when enabled, normal path otherwise.
        send_blk(128'h0, 2'd0, 3'b000, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1);
        drain();
        chk("core_queue_empty", 128'(core_q.size()), 128'(0));

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
